// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - decode-side handshake bundle of the fetch queue
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;

    modport master (
        output out_valid,
        output out_pc,
        output out_inst,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_inst,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner and DEPTH-entry {pc, inst} buffer feeding decode
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h01000000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fetch_en,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    fetch_queue_if.master              out_if,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       misalign_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  pc_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             misalign_q;

    logic [XLEN-1:0]  mem_pc   [DEPTH];
    logic [XLEN-1:0]  mem_inst [DEPTH];

    logic             not_empty;
    logic             push;
    logic             pop;

    // Handshake decode: a redirect masks the head so decode never takes a wrong-path entry.
    always_comb begin
        not_empty        = (count != '0);
        out_if.out_valid = not_empty && !redirect_valid;
        out_if.out_pc    = not_empty ? mem_pc[rd_ptr]   : '0;
        out_if.out_inst  = not_empty ? mem_inst[rd_ptr] : '0;
        pop              = out_if.out_valid && out_if.out_ready;
        push             = fetch_en && !redirect_valid &&
                           ((count < CNT_W'(DEPTH)) || pop);
    end

    assign imem_addr    = pc_q;
    assign occupancy    = count;
    assign misalign_err = misalign_q;

    // Control state: redirect flushes and reloads the PC, otherwise push/pop bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= {redirect_pc[XLEN-1:2], 2'b00};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            misalign_q <= misalign_q | (redirect_pc[1:0] != 2'b00);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                pc_q   <= pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage; never cleared, stale slots are unreachable once count is zero.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_pc[wr_ptr]   <= pc_q;
            mem_inst[wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch stage: owns the program counter and drives the instruction-memory address.
- Each fetched {pc, instruction} pair is buffered in a DEPTH-entry FIFO, which decouples fetch from decode stalls.
- Decode consumes entries through a valid/ready handshake.
- A redirect from execute (taken branch or jump) flushes the queue and reloads the PC.

Parameters:
- XLEN, 32, datapath width of PC and instruction.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h01000000, PC value loaded on reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- fetch_en  input  1  1 = fetching allowed; 0 = PC holds and nothing is pushed.
- imem_addr  output  XLEN  instruction-memory address; equals pc_q combinationally.
- imem_rdata  input  XLEN  instruction word for imem_addr, valid in the same cycle (combinational read).
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  XLEN  target PC for the redirect.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  XLEN  PC of the head entry.
- out_inst  output  XLEN  instruction of the head entry.
- occupancy  output  $clog2(DEPTH+1)  number of valid entries.
- misalign_err  output  1  sticky flag: a redirect target with low bits nonzero was seen.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_q=RESET_PC; wr_ptr=rd_ptr=0; count=0; misalign_err=0.
  - Consequently out_valid=0, out_pc=0, out_inst=0, occupancy=0.
  - Entries assert immediately and remain held while reset=0.
- Output side:
  - out_valid = (count!=0) && !redirect_valid.
  - out_pc/out_inst = head entry when count!=0, else 0.
  - pop = out_valid && out_ready.
- Push:
  - push = fetch_en && !redirect_valid && (count<DEPTH || pop).
  - On push: entry[wr_ptr] <= {pc_q, imem_rdata}; wr_ptr <= wr_ptr+1 mod DEPTH; pc_q <= pc_q+4 (XLEN-bit wrap, no overflow flag).
- Pop: rd_ptr <= rd_ptr+1 mod DEPTH.
- Count update: count <= count + push - pop. Push and pop in the same cycle leave count unchanged.
- Full with pop: push is permitted; the new entry occupies the slot freed by the pop, so throughput is 1 instr/cycle sustained at full.
- Empty: there is no bypass. An instruction fetched into an empty queue appears on out_* the next cycle. Latency imem_rdata -> out_inst is 1 cycle.
- fetch_en=0: no push, pc_q holds. Pops continue normally.
- Redirect (highest priority, single cycle):
  - At the clock edge: count<=0; wr_ptr<=0; rd_ptr<=0; pc_q <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No push and no pop occur in the redirect cycle (out_valid is forced 0), so decode never consumes a wrong-path entry in that cycle.
  - The first post-redirect fetch happens the cycle after; its entry is visible one cycle later.
  - A redirect with fetch_en=0 still flushes and reloads the PC.
  - Back-to-back redirects: the last one wins; each flushes.
- misalign_err: set to 1 at the edge of any redirect with redirect_pc[1:0]!=0. Cleared only by reset.
- occupancy = count (registered).
- Entry storage is not cleared on flush; stale data is unreachable because count=0.

Test Plan:
- Reset then fetch_en=1, out_ready=1, imem_rdata=pc^32'hA5A5A5A5 -> imem_addr steps 0x01000000, 0x01000004, ... each cycle. out_valid rises 1 cycle after reset release, and out_pc trails imem_addr by exactly 1 cycle.
- out_ready=0 for 8 cycles, DEPTH=4 -> occupancy reaches 4 after 4 cycles, then pc_q holds at 0x01000010. Release out_ready -> entries drain in order 0x01000000..0x0100000C, with no gap at the full boundary.
- Queue holding 3 entries, redirect_valid=1, redirect_pc=0x01000200, out_ready=1 -> out_valid=0 in that cycle and occupancy=0 next cycle. Next imem_addr=0x01000200, and the next out_pc=0x01000200 with no older PC ever presented.
- Redirect to 0x01000102 -> pc_q=0x01000100 and misalign_err=1. A later aligned redirect leaves misalign_err=1; reset clears it to 0.
- Random out_ready and fetch_en at 50%, DEPTH=8 and DEPTH=2, 2000 cycles -> scoreboard shows out_pc strictly +4 sequential between redirects, occupancy never exceeds DEPTH, and no entry is duplicated or lost.
- Assert reset mid-stream with the queue full -> out_valid=0, occupancy=0 and imem_addr=RESET_PC in the same cycle (asynchronous), held until reset=1.
